// File: rtl/stream_stats_pkg.sv
// Shared types and helpers for the per-frame statistics engine.
package stream_stats_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  localparam int unsigned EXT_MAX_W = 64;
  localparam int unsigned EXT_IDX_W = $clog2(EXT_MAX_W);

  // Sign- or zero-extend the low w bits of x to the full helper width.
  function automatic logic [EXT_MAX_W-1:0] ext_w(input logic [EXT_MAX_W-1:0] x,
                                                 input int unsigned          w,
                                                 input bit                   sgn);
    logic [EXT_MAX_W-1:0] keep;
    keep  = (w >= EXT_MAX_W) ? '1 : ((EXT_MAX_W'(1) << w) - EXT_MAX_W'(1));
    ext_w = (sgn && x[EXT_IDX_W'(w - 1)]) ? (x | ~keep) : (x & keep);
  endfunction

endpackage

// File: rtl/stream_stats_if.sv
// Sample stream in, frame statistics out.
interface stream_stats_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAME_LEN = 15
);
  localparam int unsigned IDX_W = $clog2(FRAME_LEN);
  localparam int unsigned SUM_W = WIDTH + $clog2(FRAME_LEN);

  logic             in_valid;
  logic [WIDTH-1:0] in_num;
  logic             out_valid;
  logic             out_abort;
  logic [WIDTH-1:0] out_max;
  logic [WIDTH-1:0] out_min;
  logic [IDX_W-1:0] out_max_idx;
  logic [IDX_W-1:0] out_min_idx;
  logic [SUM_W-1:0] out_sum;

  modport master (
    output in_valid, in_num,
    input  out_valid, out_abort, out_max, out_min, out_max_idx, out_min_idx, out_sum
  );

  modport slave (
    input  in_valid, in_num,
    output out_valid, out_abort, out_max, out_min, out_max_idx, out_min_idx, out_sum
  );
endinterface

// File: rtl/stream_stats_cmp.sv
// Strict greater/less compare of a sample against a running bound.
module stats_cmp #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] bound,
  output logic             gt_c,
  output logic             lt_c
);
  generate
    if (SIGNED) begin : g_signed
      assign gt_c = $signed(sample) > $signed(bound);
      assign lt_c = $signed(sample) < $signed(bound);
    end else begin : g_unsigned
      assign gt_c = sample > bound;
      assign lt_c = sample < bound;
    end
  endgenerate
endmodule

// File: rtl/stream_stats.sv
// Per-frame max/min/first-index/sum engine over fixed-length sample frames.
module stream_stats
  import stream_stats_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAME_LEN = 15,
  parameter bit          SIGNED    = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  stream_stats_if.slave bus
);
  localparam int unsigned      IDX_W    = $clog2(FRAME_LEN);
  localparam int unsigned      SUM_W    = WIDTH + $clog2(FRAME_LEN);
  localparam logic [0:0]       IDLE     = ST_IDLE;
  localparam logic [0:0]       ACC      = ST_ACC;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [0:0]       state, state_nxt;
  logic [IDX_W-1:0] cnt;
  logic [WIDTH-1:0] max_acc, min_acc;
  logic [IDX_W-1:0] max_idx_acc, min_idx_acc;
  logic [SUM_W-1:0] sum_acc;

  logic             seed_c, fold_c, last_c, abort_c;
  logic             max_gt_c, max_lt_c, min_gt_c, min_lt_c;
  logic [SUM_W-1:0] sample_ext_c, sum_fold_c;
  logic             unused_cmp;

  stats_cmp #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp_max (
    .sample (bus.in_num),
    .bound  (max_acc),
    .gt_c   (max_gt_c),
    .lt_c   (max_lt_c)
  );

  stats_cmp #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp_min (
    .sample (bus.in_num),
    .bound  (min_acc),
    .gt_c   (min_gt_c),
    .lt_c   (min_lt_c)
  );

  assign unused_cmp   = max_lt_c ^ min_gt_c;
  assign sample_ext_c = SUM_W'(ext_w(EXT_MAX_W'(bus.in_num), WIDTH, SIGNED));
  assign sum_fold_c   = sum_acc + sample_ext_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // cnt==0 in ACC means the previous frame just closed; a valid sample re-seeds.
  always_comb begin
    state_nxt = state;
    seed_c    = 1'b0;
    fold_c    = 1'b0;
    last_c    = 1'b0;
    abort_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          seed_c    = 1'b1;
          state_nxt = ACC;
        end
      end
      ACC: begin
        if (bus.in_valid) begin
          if (cnt == '0) begin
            seed_c = 1'b1;
          end else begin
            fold_c = 1'b1;
            last_c = (cnt == LAST_IDX);
          end
        end else begin
          abort_c   = (cnt != '0);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      max_acc     <= '0;
      min_acc     <= '0;
      max_idx_acc <= '0;
      min_idx_acc <= '0;
      sum_acc     <= '0;
    end else if (seed_c) begin
      cnt         <= IDX_W'(1);
      max_acc     <= bus.in_num;
      min_acc     <= bus.in_num;
      max_idx_acc <= '0;
      min_idx_acc <= '0;
      sum_acc     <= sample_ext_c;
    end else if (fold_c) begin
      if (max_gt_c) begin
        max_acc     <= bus.in_num;
        max_idx_acc <= cnt;
      end
      if (min_lt_c) begin
        min_acc     <= bus.in_num;
        min_idx_acc <= cnt;
      end
      sum_acc <= sum_fold_c;
      cnt     <= last_c ? '0 : cnt + IDX_W'(1);
    end else if (abort_c) begin
      cnt <= '0;
    end
  end

  // Result registers latch the folded view of the last sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.out_abort   <= 1'b0;
      bus.out_max     <= '0;
      bus.out_min     <= '0;
      bus.out_max_idx <= '0;
      bus.out_min_idx <= '0;
      bus.out_sum     <= '0;
    end else begin
      bus.out_valid <= last_c;
      bus.out_abort <= abort_c;
      if (last_c) begin
        bus.out_max     <= max_gt_c ? bus.in_num : max_acc;
        bus.out_max_idx <= max_gt_c ? cnt : max_idx_acc;
        bus.out_min     <= min_lt_c ? bus.in_num : min_acc;
        bus.out_min_idx <= min_lt_c ? cnt : min_idx_acc;
        bus.out_sum     <= sum_fold_c;
      end
    end
  end

endmodule

// File: tb/tb_stream_stats.sv
// Unsigned and signed stream_stats instances driven in lockstep against a frame-level model.
module tb_stream_stats;
  localparam int unsigned WIDTH     = 8;
  localparam int unsigned FRAME_LEN = 15;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned SUM_W     = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_stats_if #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) bus_u ();
  stream_stats_if #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) bus_s ();

  stream_stats #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .SIGNED(1'b0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_u)
  );

  stream_stats #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .SIGNED(1'b1)) u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  typedef struct {
    logic [WIDTH-1:0] mx;
    logic [WIDTH-1:0] mn;
    logic [IDX_W-1:0] mxi;
    logic [IDX_W-1:0] mni;
    logic [SUM_W-1:0] sum;
  } res_t;

  res_t             exp_u, exp_s;
  logic [WIDTH-1:0] frame_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;

  logic [WIDTH-1:0] plan_frame[FRAME_LEN] =
    '{8'd10, 8'd3, 8'd200, 8'd7, 8'd50, 8'd60, 8'd70, 8'd80,
      8'd90, 8'd100, 8'd110, 8'd120, 8'd130, 8'd140, 8'd150};
  logic [WIDTH-1:0] signed_frame[FRAME_LEN] =
    '{8'd5, 8'd128, 8'd20, 8'd127, 8'd255, 8'd0, 8'd1, 8'd2,
      8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic over the collected frame samples.
  function automatic res_t frame_result(input bit sgn);
    res_t                    r;
    int                      mx, mn, sum, v;
    logic signed [WIDTH-1:0] sv;
    mx = 0; mn = 0; sum = 0;
    r.mxi = '0; r.mni = '0;
    foreach (frame_q[i]) begin
      sv = frame_q[i];
      if (sgn) v = sv;
      else     v = int'(frame_q[i]);
      if (i == 0 || v > mx) begin mx = v; r.mxi = IDX_W'(i); end
      if (i == 0 || v < mn) begin mn = v; r.mni = IDX_W'(i); end
      sum += v;
    end
    r.mx  = WIDTH'(mx);
    r.mn  = WIDTH'(mn);
    r.sum = SUM_W'(sum);
    return r;
  endfunction

  task automatic check_all(input logic ev, input logic ea);
    chk("u_valid",   32'(bus_u.out_valid),   32'(ev));
    chk("u_abort",   32'(bus_u.out_abort),   32'(ea));
    chk("u_max",     32'(bus_u.out_max),     32'(exp_u.mx));
    chk("u_min",     32'(bus_u.out_min),     32'(exp_u.mn));
    chk("u_max_idx", 32'(bus_u.out_max_idx), 32'(exp_u.mxi));
    chk("u_min_idx", 32'(bus_u.out_min_idx), 32'(exp_u.mni));
    chk("u_sum",     32'(bus_u.out_sum),     32'(exp_u.sum));
    chk("s_valid",   32'(bus_s.out_valid),   32'(ev));
    chk("s_abort",   32'(bus_s.out_abort),   32'(ea));
    chk("s_max",     32'(bus_s.out_max),     32'(exp_s.mx));
    chk("s_min",     32'(bus_s.out_min),     32'(exp_s.mn));
    chk("s_max_idx", 32'(bus_s.out_max_idx), 32'(exp_s.mxi));
    chk("s_min_idx", 32'(bus_s.out_min_idx), 32'(exp_s.mni));
    chk("s_sum",     32'(bus_s.out_sum),     32'(exp_s.sum));
  endtask

  // Drive one cycle, advance the model, check just after the edge.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] n);
    logic ev, ea;
    bus_u.in_valid = v; bus_u.in_num = n;
    bus_s.in_valid = v; bus_s.in_num = n;
    @(posedge clk); #1;
    ev = 1'b0; ea = 1'b0;
    if (v) begin
      frame_q.push_back(n);
      if (frame_q.size() == FRAME_LEN) begin
        exp_u = frame_result(1'b0);
        exp_s = frame_result(1'b1);
        ev    = 1'b1;
        frame_q.delete();
      end
    end else if (frame_q.size() != 0) begin
      ea = 1'b1;
      frame_q.delete();
    end
    check_all(ev, ea);
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    exp_u = '{default: '0};
    exp_s = '{default: '0};
    frame_q.delete();
    check_all(1'b0, 1'b0);
    bus_u.in_valid = 1'b0; bus_s.in_valid = 1'b0;
    @(posedge clk); #1;
    check_all(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    bus_u.in_valid = 1'b0; bus_u.in_num = '0;
    bus_s.in_valid = 1'b0; bus_s.in_num = '0;
    exp_u = '{default: '0};
    exp_s = '{default: '0};
    #12;
    check_all(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Known frame with hand-computed results.
    foreach (plan_frame[i]) cycle(1'b1, plan_frame[i]);
    chk("plan_max",     32'(bus_u.out_max),     32'd200);
    chk("plan_min",     32'(bus_u.out_min),     32'd3);
    chk("plan_max_idx", 32'(bus_u.out_max_idx), 32'd2);
    chk("plan_min_idx", 32'(bus_u.out_min_idx), 32'd1);
    chk("plan_sum",     32'(bus_u.out_sum),     32'd1320);
    cycle(1'b0, '0);

    // All-equal frame: ties keep index 0.
    repeat (FRAME_LEN) cycle(1'b1, 8'd5);
    chk("tie_max_idx", 32'(bus_u.out_max_idx), 32'd0);
    chk("tie_min_idx", 32'(bus_u.out_min_idx), 32'd0);
    chk("tie_sum",     32'(bus_u.out_sum),     32'd75);
    cycle(1'b0, '0);

    // Three back-to-back frames: ramp up, ramp down, constant.
    for (int i = 0; i < int'(FRAME_LEN); i++) cycle(1'b1, WIDTH'(i * 10));
    for (int i = 0; i < int'(FRAME_LEN); i++) cycle(1'b1, WIDTH'(255 - i * 7));
    repeat (FRAME_LEN) cycle(1'b1, 8'd42);
    cycle(1'b0, '0);

    // Abort after 7 samples, then a clean frame.
    repeat (7) cycle(1'b1, WIDTH'($urandom));
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    repeat (FRAME_LEN) cycle(1'b1, WIDTH'($urandom));
    cycle(1'b0, '0);

    // Extreme signed values.
    foreach (signed_frame[i]) cycle(1'b1, signed_frame[i]);
    chk("sgn_max", 32'(bus_s.out_max), 32'h7f);
    chk("sgn_min", 32'(bus_s.out_min), 32'h80);
    chk("sgn_sum", 32'(bus_s.out_sum), 32'd73);
    chk("uns_sum", 32'(bus_u.out_sum), 32'd585);
    cycle(1'b0, '0);

    // Reset in the middle of a frame, then a full frame.
    repeat (9) cycle(1'b1, WIDTH'($urandom));
    mid_reset();
    repeat (FRAME_LEN) cycle(1'b1, WIDTH'($urandom));

    // Random traffic with occasional gaps.
    for (int i = 0; i < 400; i++) cycle(($urandom_range(0, 9) != 0), WIDTH'($urandom));
    cycle(1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
